// File: rtl/vga_glyph_blitter_pkg.sv
// Shared definitions for the glyph blitter: FSM state encoding and screen geometry.
package vga_glyph_blitter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DRAW,
    ST_DONE
  } state_t;

  localparam int unsigned SCREEN_W   = 160;
  localparam int unsigned SCREEN_H   = 120;
  localparam int unsigned COLOUR_W   = 3;
  localparam int unsigned GLYPH_ROWS = 8;

endpackage

// File: rtl/vga_glyph_blitter_rise_detect.sv
// Registered history of a level input and a 0->1 detection on it.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/vga_glyph_blitter.sv
// Draws one 8x8 glyph per start edge: fetches each bitmap row from a synchronous ROM,
// then issues one adapter write per pixel, clipping anything off the visible screen.
module vga_glyph_blitter
  import vga_glyph_blitter_pkg::*;
#(
  parameter int unsigned         X_MAX     = SCREEN_W - 1,
  parameter int unsigned         Y_MAX     = SCREEN_H - 1,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          x_in,
  input  logic [6:0]          y_in,
  input  logic [1:0]          glyph,
  input  logic [COLOUR_W-1:0] fg_colour,
  input  logic                bg_en,
  output logic [4:0]          rom_addr,
  input  logic [7:0]          rom_data,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                done
);

  localparam logic [8:0] X_LIM = 9'(X_MAX);
  localparam logic [7:0] Y_LIM = 8'(Y_MAX);

  state_t state, state_nxt;

  logic                start_rise;
  logic                launch;
  logic [2:0]          row;
  logic [2:0]          col;
  logic [7:0]          shift;
  logic [7:0]          x_r;
  logic [6:0]          y_r;
  logic [1:0]          glyph_r;
  logic [COLOUR_W-1:0] fg_r;
  logic                bg_r;
  logic [7:0]          hold_x;
  logic [6:0]          hold_y;
  logic [COLOUR_W-1:0] hold_colour;

  logic [8:0]          sum_x;
  logic [7:0]          sum_y;
  logic                pix_bit;
  logic                in_view;
  logic                draw_plot;
  logic [COLOUR_W-1:0] draw_colour;

  rise_detect u_start_rise (
    .clk   (clk),
    .reset (reset),
    .d     (start),
    .rise  (start_rise)
  );

  assign launch = start_rise && (state == ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (launch) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_DRAW;
      ST_DRAW: begin
        if (col == 3'd7) begin
          state_nxt = (row == 3'(GLYPH_ROWS - 1)) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row     <= '0;
      col     <= '0;
      shift   <= '0;
      x_r     <= '0;
      y_r     <= '0;
      glyph_r <= '0;
      fg_r    <= '0;
      bg_r    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            row     <= '0;
            x_r     <= x_in;
            y_r     <= y_in;
            glyph_r <= glyph;
            fg_r    <= fg_colour;
            bg_r    <= bg_en;
          end
        end
        ST_WAIT: begin
          shift <= rom_data;
          col   <= '0;
        end
        ST_DRAW: begin
          col <= col + 3'd1;
          if (col == 3'd7 && row != 3'(GLYPH_ROWS - 1)) begin
            row <= row + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sums are one bit wider than the coordinates so off-screen pixels clip instead of wrapping.
  assign sum_x       = {1'b0, x_r} + {6'b0, col};
  assign sum_y       = {1'b0, y_r} + {5'b0, row};
  assign pix_bit     = shift[3'd7 - col];
  assign in_view     = (sum_x <= X_LIM) && (sum_y <= Y_LIM);
  assign draw_plot   = (state == ST_DRAW) && in_view && (pix_bit || bg_r);
  assign draw_colour = pix_bit ? fg_r : BG_COLOUR;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_x      <= '0;
      hold_y      <= '0;
      hold_colour <= '0;
    end else if (draw_plot) begin
      hold_x      <= sum_x[7:0];
      hold_y      <= sum_y[6:0];
      hold_colour <= draw_colour;
    end
  end

  // Pixel outputs are live during a write and otherwise show the last pixel written.
  assign vga_plot   = draw_plot;
  assign vga_x      = draw_plot ? sum_x[7:0] : hold_x;
  assign vga_y      = draw_plot ? sum_y[6:0] : hold_y;
  assign vga_colour = draw_plot ? draw_colour : hold_colour;

  assign rom_addr = {glyph_r, row};
  assign busy     = (state == ST_FETCH) || (state == ST_WAIT) || (state == ST_DRAW);
  assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_vga_glyph_blitter.sv
// Scoreboard bench for vga_glyph_blitter: stimulus queues expected pixels/done pulses, a monitor checks them.
module tb_vga_glyph_blitter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [1:0] glyph = '0;
  logic [2:0] fg_colour = '0;
  logic       bg_en = 1'b0;
  logic [4:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  vga_glyph_blitter dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .x_in       (x_in),
    .y_in       (y_in),
    .glyph      (glyph),
    .fg_colour  (fg_colour),
    .bg_en      (bg_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [32];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int x;
    int y;
    int c;
    int cy;
  } pix_t;

  pix_t plot_q [$];
  int   done_q [$];
  int   compared = 0;
  int   mismatched = 0;
  int   plot_cnt = 0;
  int   fetch_base = -1;
  int   cur_glyph = 0;

  function automatic void chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: consumes expectations as the DUT produces writes and done pulses.
  always @(negedge clk) begin
    if (reset) begin
      if (vga_plot) begin
        plot_cnt++;
        if (plot_q.size() == 0) begin
          chk("unexpected_plot", 1, 0);
        end else begin
          pix_t p;
          p = plot_q.pop_front();
          chk("plot_x", int'(vga_x), p.x);
          chk("plot_y", int'(vga_y), p.y);
          chk("plot_colour", int'(vga_colour), p.c);
          chk("plot_cycle", cyc, p.cy);
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_cycle", cyc, done_q.pop_front());
      end
      if (fetch_base >= 0) begin
        int off;
        off = cyc - fetch_base;
        if (off >= 0 && off <= 80) begin
          chk("busy", int'(busy), (off < 80) ? 1 : 0);
          if (off % 10 == 0 && off < 80) chk("rom_addr", int'(rom_addr), cur_glyph * 8 + off / 10);
          if (off == 80) fetch_base = -1;
        end
      end
    end
  end

  // Raises start on a negedge; the following posedge is the launch edge, whose cycle is e.
  task automatic launch(input int x, input int y, input int g, input int fg, input int bg, output int e);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    e = cyc + 1;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        logic [7:0] w;
        int sx, sy;
        w  = rom[g * 8 + r];
        sx = x + c;
        sy = y + r;
        if (sx <= 159 && sy <= 119 && (w[7 - c] || bg != 0))
          plot_q.push_back('{sx, sy, w[7 - c] ? fg : 0, e + 2 + 10 * r + c});
      end
    end
    done_q.push_back(e + 80);
    cur_glyph  = g;
    fetch_base = e;
    plot_cnt   = 0;
    x_in       = 8'(x);
    y_in       = 7'(y);
    glyph      = 2'(g);
    fg_colour  = 3'(fg);
    bg_en      = 1'(bg);
    start      = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 150 && (plot_q.size() != 0 || done_q.size() != 0); i++) @(negedge clk);
    if (plot_q.size() != 0 || done_q.size() != 0) begin
      chk("drain_timeout", plot_q.size() + done_q.size(), 0);
      plot_q.delete();
      done_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e;
    for (int i = 0; i < 8; i++) begin
      rom[i]      = 8'hA5;
      rom[8 + i]  = 8'hFF;
      rom[16 + i] = 8'h3C;
      rom[24 + i] = 8'h80 >> i;
    end

    #2;
    chk("reset_plot", int'(vga_plot), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_rom_addr", int'(rom_addr), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // 1: A5 rows, foreground only
    launch(10, 20, 0, 5, 0, e);
    drain();
    chk("t1_plot_count", plot_cnt, 32);
    chk("t1_hold_x", int'(vga_x), 17);
    chk("t1_hold_y", int'(vga_y), 27);

    // 2: A5 rows with background fill
    launch(10, 20, 0, 3, 1, e);
    drain();
    chk("t2_plot_count", plot_cnt, 64);

    // 3: clipped at the bottom-right corner
    launch(155, 115, 1, 6, 0, e);
    drain();
    chk("t3_plot_count", plot_cnt, 25);
    chk("t3_hold_x", int'(vga_x), 159);
    chk("t3_hold_y", int'(vga_y), 119);

    // 4a: start held high 200 cycles gives exactly one glyph
    launch(30, 30, 2, 1, 0, e);
    repeat (200) @(negedge clk);
    chk("t4_held_queue", plot_q.size() + done_q.size(), 0);
    chk("t4_held_count", plot_cnt, 32);
    start = 1'b0;

    // 4b: a fresh edge while busy is dropped; one after done is accepted
    launch(30, 30, 2, 2, 0, e);
    @(negedge clk);
    start = 1'b0;
    while (cyc < e + 38) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (20) @(negedge clk);
    chk("t4_busy_pulse_count", plot_cnt, 32);
    launch(60, 60, 2, 4, 0, e);
    @(negedge clk);
    start = 1'b0;
    drain();
    chk("t4_after_done_count", plot_cnt, 32);

    // 5: reset mid-glyph aborts without a done pulse
    launch(0, 0, 0, 7, 0, e);
    @(negedge clk);
    start = 1'b0;
    while (cyc < e + 29) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_plot", int'(vga_plot), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_rom_addr", int'(rom_addr), 0);
    chk("t5_vga_x", int'(vga_x), 0);
    chk("t5_vga_y", int'(vga_y), 0);
    chk("t5_vga_colour", int'(vga_colour), 0);
    plot_q.delete();
    done_q.delete();
    fetch_base = -1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    launch(0, 0, 0, 7, 0, e);
    @(negedge clk);
    start = 1'b0;
    drain();
    chk("t5_redraw_count", plot_cnt, 32);

    // 6: glyph 3 fetches ROM words 24..31 (checked by the monitor), diagonal bitmap
    launch(40, 50, 3, 2, 0, e);
    @(negedge clk);
    start = 1'b0;
    drain();
    chk("t6_plot_count", plot_cnt, 8);
    chk("t6_hold_x", int'(vga_x), 47);
    chk("t6_hold_y", int'(vga_y), 57);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
